// File: rtl/ttt_pkg.sv
// Shared types and helpers for the N x N tic-tac-toe engine.
// Cells are stored row-major, two bits per cell.
package ttt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      P1_TURN = 2'b00,
      P2_TURN = 2'b01,
      CHECK   = 2'b10,
      DONE    = 2'b11
   } state_t;

   localparam logic [1:0] TURN_P1   = 2'b01;
   localparam logic [1:0] TURN_P2   = 2'b10;
   localparam logic [1:0] TURN_NONE = 2'b00;

   function automatic int cell_idx(input int row, input int col, input int side);
      return row * side + col;
   endfunction

   function automatic cell_t other_player(input cell_t p);
      return (p == P1) ? P2 : P1;
   endfunction

endpackage

// File: rtl/ttt_engine_nxn_win.sv
// Combinational WIN_LEN-in-a-row detector over an N x N board for one player.
// Every window position and direction is elaborated as its own AND term.
module win_detect_nxn
   import ttt_pkg::*;
#(
   parameter int N       = 3,
   parameter int WIN_LEN = 3
) (
   input  logic [2*N*N-1:0] board,
   input  cell_t            player,
   output logic             win
);

   localparam int CELLS = N * N;

   logic [CELLS-1:0]   mine;
   logic [4*CELLS-1:0] hits;

   for (genvar i = 0; i < CELLS; i++) begin : g_mine
      assign mine[i] = (board[2*i +: 2] == player);
   end

   // Direction d: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
   for (genvar d = 0; d < 4; d++) begin : g_dir
      localparam int DR = (d == 0) ? 0 : 1;
      localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      for (genvar r = 0; r < N; r++) begin : g_row
         for (genvar c = 0; c < N; c++) begin : g_col
            localparam int R_END = r + (WIN_LEN - 1) * DR;
            localparam int C_END = c + (WIN_LEN - 1) * DC;
            if (R_END < N && C_END >= 0 && C_END < N) begin : g_fit
               logic [WIN_LEN-1:0] run;
               for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                  assign run[k] = mine[cell_idx(r + k*DR, c + k*DC, N)];
               end
               assign hits[d*CELLS + cell_idx(r, c, N)] = &run;
            end else begin : g_nofit
               assign hits[d*CELLS + cell_idx(r, c, N)] = 1'b0;
            end
         end
      end
   end

   assign win = |hits;

endmodule

// File: rtl/ttt_engine_nxn.sv
// N x N tic-tac-toe engine: board register, turn FSM, move validation, win/draw result.
// Optional turn timer is compiled in with `define TURN_TIMER_EN.
module ttt_engine_nxn
   import ttt_pkg::*;
#(
   parameter int  N            = 3,
   parameter int  WIN_LEN      = 3,
   parameter int  TURN_TIMEOUT = 500,
   localparam int CELLS        = N * N,
   localparam int PW           = $clog2(CELLS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic               j1_valid,
   input  logic [PW-1:0]      j1_pos,
   input  logic               j2_valid,
   input  logic [PW-1:0]      j2_pos,
   output logic [2*CELLS-1:0] board,
   output logic [1:0]         turn,
   output logic [1:0]         winner,
   output logic               draw,
   output logic               game_over,
   output logic               illegal,
   output logic               timeout,
   output state_t             dbg_state
);

   // Handshake: a move is a single-cycle jx_valid/jx_pos sample; there is no
   // ready. Only the player whose turn it is gets an answer: the board changes
   // (accept) or illegal pulses the following cycle (reject). Anything else is dropped.

   state_t             state_q, state_d;
   logic [2*CELLS-1:0] board_q, board_d;
   cell_t              mover_q, mover_d;
   logic [1:0]         winner_q, winner_d;
   logic               draw_q, draw_d;
   logic               illegal_q, illegal_d;
   logic [1:0]         turn_q, turn_d;
   logic               game_over_q, game_over_d;

   logic               cur_valid;
   logic [PW-1:0]      cur_pos;
   cell_t              cur_player;
   logic               in_range;
   logic [PW-1:0]      pos_idx;
   logic [PW:0]        bit_idx;
   logic               occupied;
   logic               accept;
   logic               reject;
   logic               win;
   logic               board_full;
   logic [CELLS-1:0]   occ;

`ifdef TURN_TIMER_EN
   localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_q, timeout_d;
   logic          timer_expired;
   assign timer_expired = (timer_q == TW'(TURN_TIMEOUT - 1));
`endif

   for (genvar g = 0; g < CELLS; g++) begin : g_occ
      assign occ[g] = |board_q[2*g +: 2];
   end
   assign board_full = &occ;

   // Only the player who just moved is tested; the other cannot have changed.
   win_detect_nxn #(
      .N       (N),
      .WIN_LEN (WIN_LEN)
   ) u_win (
      .board  (board_q),
      .player (mover_q),
      .win    (win)
   );

   always_comb begin
      cur_valid  = 1'b0;
      cur_pos    = '0;
      cur_player = P1;
      case (state_q)
         P1_TURN: begin
            cur_valid  = j1_valid;
            cur_pos    = j1_pos;
            cur_player = P1;
         end
         P2_TURN: begin
            cur_valid  = j2_valid;
            cur_pos    = j2_pos;
            cur_player = P2;
         end
         default: ;
      endcase
   end

   assign in_range = ({1'b0, cur_pos} < (PW+1)'(CELLS));
   assign pos_idx  = in_range ? cur_pos : '0;
   assign bit_idx  = {pos_idx, 1'b0};
   assign occupied = (board_q[bit_idx +: 2] != EMPTY);
   assign accept   = cur_valid && in_range && !occupied;
   assign reject   = cur_valid && !accept;

   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      mover_d   = mover_q;
      winner_d  = winner_q;
      draw_d    = draw_q;
      illegal_d = 1'b0;
`ifdef TURN_TIMER_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
         P1_TURN, P2_TURN: begin
            if (accept) begin
               board_d[bit_idx +: 2] = cur_player;
               mover_d               = cur_player;
               state_d               = CHECK;
            end else if (reject) begin
               illegal_d = 1'b1;
`ifdef TURN_TIMER_EN
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               state_d   = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
`endif
            end
         end
         CHECK: begin
            if (win) begin
               winner_d = mover_q;
               state_d  = DONE;
            end else if (board_full) begin
               draw_d  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = (other_player(mover_q) == P1) ? P1_TURN : P2_TURN;
            end
         end
         default: ;
      endcase

      case (state_d)
         P1_TURN: turn_d = TURN_P1;
         P2_TURN: turn_d = TURN_P2;
         default: turn_d = TURN_NONE;
      endcase
      game_over_d = (state_d == DONE);

`ifdef TURN_TIMER_EN
      // Counter restarts whenever a turn begins or a move is rejected.
      if (state_d inside {P1_TURN, P2_TURN}) begin
         if (state_d != state_q || illegal_d) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end else begin
         timer_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         state_q     <= P1_TURN;
         board_q     <= '0;
         mover_q     <= EMPTY;
         winner_q    <= 2'b00;
         draw_q      <= 1'b0;
         illegal_q   <= 1'b0;
         turn_q      <= TURN_P1;
         game_over_q <= 1'b0;
`ifdef TURN_TIMER_EN
         timer_q     <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         mover_q     <= mover_d;
         winner_q    <= winner_d;
         draw_q      <= draw_d;
         illegal_q   <= illegal_d;
         turn_q      <= turn_d;
         game_over_q <= game_over_d;
`ifdef TURN_TIMER_EN
         timer_q     <= timer_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign board     = board_q;
   assign turn      = turn_q;
   assign winner    = winner_q;
   assign draw      = draw_q;
   assign game_over = game_over_q;
   assign illegal   = illegal_q;
   assign dbg_state = state_q;
`ifdef TURN_TIMER_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_engine_nxn.sv
// Bench for ttt_engine_nxn: a 3x3 instance and a 5x5/WIN_LEN=4 instance against a game-rule model.
// Define TURN_TIMER_EN to build and check the turn-timer variant.
module tb_ttt_engine_nxn;
   import ttt_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_new_game, a_j1_valid, a_j2_valid;
   logic [3:0]  a_j1_pos, a_j2_pos;
   logic [17:0] a_board;
   logic [1:0]  a_turn, a_winner;
   logic        a_draw, a_game_over, a_illegal, a_timeout;
   state_t      a_dbg;

   logic        b_new_game, b_j1_valid, b_j2_valid;
   logic [4:0]  b_j1_pos, b_j2_pos;
   logic [49:0] b_board;
   logic [1:0]  b_turn, b_winner;
   logic        b_draw, b_game_over, b_illegal, b_timeout;
   state_t      b_dbg;

   ttt_engine_nxn #(.N(3), .WIN_LEN(3), .TURN_TIMEOUT(10)) dut3 (
      .clk(clk), .rst(rst), .new_game(a_new_game),
      .j1_valid(a_j1_valid), .j1_pos(a_j1_pos),
      .j2_valid(a_j2_valid), .j2_pos(a_j2_pos),
      .board(a_board), .turn(a_turn), .winner(a_winner), .draw(a_draw),
      .game_over(a_game_over), .illegal(a_illegal), .timeout(a_timeout),
      .dbg_state(a_dbg)
   );

   ttt_engine_nxn #(.N(5), .WIN_LEN(4), .TURN_TIMEOUT(500)) dut5 (
      .clk(clk), .rst(rst), .new_game(b_new_game),
      .j1_valid(b_j1_valid), .j1_pos(b_j1_pos),
      .j2_valid(b_j2_valid), .j2_pos(b_j2_pos),
      .board(b_board), .turn(b_turn), .winner(b_winner), .draw(b_draw),
      .game_over(b_game_over), .illegal(b_illegal), .timeout(b_timeout),
      .dbg_state(b_dbg)
   );

   // ---------------- game model ----------------
   int cells [2][64];
   int m_turn [2];
   bit m_done [2];
   int m_winner [2];
   bit m_draw [2];
   int m_side [2];
   int m_k [2];
   int total = 0;
   int bad   = 0;

   logic [63:0] o_board;
   logic [1:0]  o_turn, o_winner;
   logic        o_draw, o_go, o_ill, o_to;

   function automatic void model_reset(input int sel);
      for (int i = 0; i < 64; i++) cells[sel][i] = 0;
      m_turn[sel]   = 1;
      m_done[sel]   = 1'b0;
      m_winner[sel] = 0;
      m_draw[sel]   = 1'b0;
   endfunction

   function automatic bit model_win(input int sel, input int p);
      int n, k, dr, dc, run, rr, cc;
      n = m_side[sel];
      k = m_k[sel];
      for (int d = 0; d < 4; d++) begin
         dr = (d == 0) ? 0 : 1;
         dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
         for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
               run = 0;
               for (int s = 0; s < k; s++) begin
                  rr = r + s * dr;
                  cc = c + s * dc;
                  if (rr >= 0 && rr < n && cc >= 0 && cc < n && cells[sel][rr*n + cc] == p) run++;
               end
               if (run == k) return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   function automatic bit model_full(input int sel);
      for (int i = 0; i < m_side[sel] * m_side[sel]; i++) begin
         if (cells[sel][i] == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [63:0] exp_board(input int sel);
      logic [63:0] b;
      b = '0;
      for (int i = 0; i < m_side[sel] * m_side[sel]; i++) b[2*i +: 2] = 2'(cells[sel][i]);
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input int sel, input bit v1, input int p1, input bit v2, input int p2, input bit ng);
      if (sel == 0) begin
         a_j1_valid = v1; a_j1_pos = 4'(p1);
         a_j2_valid = v2; a_j2_pos = 4'(p2);
         a_new_game = ng;
      end else begin
         b_j1_valid = v1; b_j1_pos = 5'(p1);
         b_j2_valid = v2; b_j2_pos = 5'(p2);
         b_new_game = ng;
      end
   endtask

   task automatic grab(input int sel);
      if (sel == 0) begin
         o_board = 64'(a_board); o_turn = a_turn; o_winner = a_winner;
         o_draw = a_draw; o_go = a_game_over; o_ill = a_illegal; o_to = a_timeout;
      end else begin
         o_board = 64'(b_board); o_turn = b_turn; o_winner = b_winner;
         o_draw = b_draw; o_go = b_game_over; o_ill = b_illegal; o_to = b_timeout;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input int sel, input string tag, input bit exp_ill, input bit exp_to);
      grab(sel);
      check({tag, ".board"},     o_board,       exp_board(sel));
      check({tag, ".turn"},      64'(o_turn),   m_done[sel] ? 64'd0 : 64'(m_turn[sel]));
      check({tag, ".winner"},    64'(o_winner), 64'(m_winner[sel]));
      check({tag, ".draw"},      64'(o_draw),   64'(m_draw[sel]));
      check({tag, ".game_over"}, 64'(o_go),     64'(m_done[sel]));
      check({tag, ".illegal"},   64'(o_ill),    64'(exp_ill));
      check({tag, ".timeout"},   64'(o_to),     64'(exp_to));
   endtask

   task automatic step(input int sel, input bit v1, input int p1, input bit v2, input int p2, input string tag);
      int cur, pos;
      bit v;
      drive(sel, v1, p1, v2, p2, 1'b0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0);
      cur = m_turn[sel];
      v   = m_done[sel] ? 1'b0 : ((cur == 1) ? v1 : v2);
      pos = (cur == 1) ? p1 : p2;
      if (!v) begin
         check_all(sel, tag, 1'b0, 1'b0);
      end else if (pos >= m_side[sel] * m_side[sel] || cells[sel][pos] != 0) begin
         check_all(sel, tag, 1'b1, 1'b0);
      end else begin
         cells[sel][pos] = cur;
         grab(sel);
         check({tag, ".acc_board"}, o_board,     exp_board(sel));
         check({tag, ".acc_turn"},  64'(o_turn), 64'd0);
         check({tag, ".acc_go"},    64'(o_go),   64'd0);
         @(posedge clk); #1;
         if (model_win(sel, cur)) begin
            m_done[sel]   = 1'b1;
            m_winner[sel] = cur;
         end else if (model_full(sel)) begin
            m_done[sel] = 1'b1;
            m_draw[sel] = 1'b1;
         end else begin
            m_turn[sel] = 3 - cur;
         end
         check_all(sel, {tag, ".res"}, 1'b0, 1'b0);
      end
   endtask

   task automatic play(input int sel, input int player, input int pos, input string tag);
      if (player == 1) step(sel, 1'b1, pos, 1'b0, 0, tag);
      else             step(sel, 1'b0, 0, 1'b1, pos, tag);
   endtask

   task automatic restart(input int sel, input string tag);
      drive(sel, 1'b1, 4, 1'b1, 2, 1'b1);
      @(posedge clk); #1;
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0);
      model_reset(sel);
      check_all(sel, tag, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int sel, n2, pos, opos, cur, start;
      bit wrong, last_wrong, both;
      m_side[0] = 3; m_k[0] = 3;
      m_side[1] = 5; m_k[1] = 4;
      rst = 1'b1;
      drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
      drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset(0);
      model_reset(1);
      check_all(0, "reset3", 1'b0, 1'b0);
      check_all(1, "reset5", 1'b0, 1'b0);

      // P1 takes the top row while P2 plays 3,4
      play(0, 1, 0, "t1_p1_0");
      play(0, 2, 3, "t1_p2_3");
      play(0, 1, 1, "t1_p1_1");
      play(0, 2, 4, "t1_p2_4");
      play(0, 1, 2, "t1_p1_2");
      check("t1_winner", 64'(a_winner), 64'd1);
      play(0, 2, 5, "t1_done_ignored");

      // Occupied cell from P2
      restart(0, "t2_restart");
      play(0, 1, 0, "t2_p1_0");
      play(0, 2, 0, "t2_p2_occupied");
      check("t2_turn_kept", 64'(a_turn), 64'd2);
      step(0, 1'b0, 0, 1'b0, 0, "t2_idle");
      play(0, 2, 1, "t2_p2_1");

      // Out-of-range, wrong player, both valid
      restart(0, "t3_restart");
      play(0, 1, 9, "t3_pos9");
      step(0, 1'b0, 0, 1'b0, 0, "t3_idle");
      play(0, 1, 15, "t3_pos15");
      play(0, 2, 5, "t3_wrong_player");
      step(0, 1'b1, 4, 1'b1, 4, "t3_both_valid");
      step(0, 1'b1, 6, 1'b1, 8, "t3_both_valid_p2");

      // Draw: X O X / X O O / O X X
      restart(0, "t4_restart");
      play(0, 1, 0, "t4_a"); play(0, 2, 1, "t4_b");
      play(0, 1, 2, "t4_c"); play(0, 2, 4, "t4_d");
      play(0, 1, 3, "t4_e"); play(0, 2, 5, "t4_f");
      play(0, 1, 7, "t4_g"); play(0, 2, 6, "t4_h");
      play(0, 1, 8, "t4_i");
      check("t4_draw", 64'(a_draw), 64'd1);
      check("t4_winner", 64'(a_winner), 64'd0);

      // 5x5, four in a row: P1 anti-diagonal, P2 stops at three
      play(1, 1, 4, "t5_a");  play(1, 2, 0, "t5_b");
      play(1, 1, 8, "t5_c");  play(1, 2, 1, "t5_d");
      play(1, 1, 12, "t5_e"); play(1, 2, 2, "t5_f");
      check("t5_three_no_win", 64'(b_game_over), 64'd0);
      play(1, 1, 16, "t5_g");
      check("t5_winner", 64'(b_winner), 64'd1);

      // Rst mid-game
      restart(1, "t5_restart");
      play(1, 1, 24, "t5_move");
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset(0);
      model_reset(1);
      check_all(1, "rst_mid5", 1'b0, 1'b0);
      check_all(0, "rst_mid3", 1'b0, 1'b0);

`ifdef TURN_TIMER_EN
      restart(0, "t6_restart");
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         check_all(0, "t6_idle", 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      m_turn[0] = 2;
      check_all(0, "t6_timeout", 1'b0, 1'b1);
      play(0, 2, 4, "t6_p2_after");
      play(0, 1, 0, "t6_p1_after");
`else
      restart(0, "t6_restart");
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check_all(0, "t6_wait", 1'b0, 1'b0);
      end
`endif

      // Random games on both boards
      for (int g = 0; g < 10; g++) begin
         sel = g % 2;
         restart(sel, "rnd_restart");
         last_wrong = 1'b0;
         n2 = m_side[sel] * m_side[sel];
         for (int s = 0; s < 120 && !m_done[sel]; s++) begin
            pos = $urandom_range(0, n2);
            if ($urandom_range(0, 3) != 0) begin
               start = $urandom_range(0, n2 - 1);
               for (int j = 0; j < n2; j++) begin
                  if (cells[sel][(start + j) % n2] == 0) begin
                     pos = (start + j) % n2;
                     break;
                  end
               end
            end
            opos  = $urandom_range(0, n2 - 1);
            wrong = !last_wrong && ($urandom_range(0, 4) == 0);
            both  = ($urandom_range(0, 7) == 0);
            cur   = m_turn[sel];
            if (wrong) begin
               if (cur == 1) step(sel, 1'b0, 0, 1'b1, pos, "rnd_wrong");
               else          step(sel, 1'b1, pos, 1'b0, 0, "rnd_wrong");
            end else if (cur == 1) begin
               step(sel, 1'b1, pos, both, opos, "rnd_p1");
            end else begin
               step(sel, both, opos, 1'b1, pos, "rnd_p2");
            end
            last_wrong = wrong;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
